// File: rtl/riscv_pkg.sv
// Shared definitions for the 5-stage RISC-V core: datapath width, mux and ALU
// encodings, and the control bundle carried through the ID/EX register.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_IDX_W  = 5;
    localparam int ALU_CTRL_W = 3;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef enum logic [ALU_CTRL_W-1:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_U = 2'b11
    } imm_src_e;

    // Control group, including the slot-valid flag so a bubble clears it too.
    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        jump;
        logic        branch;
        logic        alu_src;
        result_src_e result_src;
        alu_ctrl_e   alu_control;
        logic        valid;
    } ex_ctrl_t;

    localparam int EX_CTRL_W = $bits(ex_ctrl_t);

    function automatic int ex_data_width(input int xlen);
        return 5 * xlen + 3 * REG_IDX_W;
    endfunction

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register: synchronous active-low reset, synchronous clear
// (takes priority over enable) and load enable.
module pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/id_ex_register.sv
// Decode/Execute pipeline register with hazard stall/flush and a saturating
// count of bubbles inserted into the execute slot.
module id_ex_register #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             StallE,
    input  logic             FlushE,
    input  logic             ValidD,
    input  logic [XLEN-1:0]  RD1D,
    input  logic [XLEN-1:0]  RD2D,
    input  logic [XLEN-1:0]  ImmExtD,
    input  logic [XLEN-1:0]  PCD,
    input  logic [XLEN-1:0]  PCPlus4D,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdD,
    input  logic             RegWriteD,
    input  logic             MemWriteD,
    input  logic             JumpD,
    input  logic             BranchD,
    input  logic             ALUSrcD,
    input  logic [1:0]       ResultSrcD,
    input  logic [2:0]       ALUControlD,
    output logic [XLEN-1:0]  RD1E,
    output logic [XLEN-1:0]  RD2E,
    output logic [XLEN-1:0]  ImmExtE,
    output logic [XLEN-1:0]  PCE,
    output logic [XLEN-1:0]  PCPlus4E,
    output logic [4:0]       Rs1E,
    output logic [4:0]       Rs2E,
    output logic [4:0]       RdE,
    output logic             RegWriteE,
    output logic             MemWriteE,
    output logic             JumpE,
    output logic             BranchE,
    output logic             ALUSrcE,
    output logic [1:0]       ResultSrcE,
    output logic [2:0]       ALUControlE,
    output logic             ValidE,
    output logic [CNT_W-1:0] BubbleCntE
);

    import riscv_pkg::*;

    localparam int DATA_W = ex_data_width(XLEN);

    // StallE/FlushE are level requests sampled at the rising edge only; a
    // flush wins over a stall, and reset wins over both.
    logic              w_load;
    logic              w_bubble;
    logic [DATA_W-1:0] w_data_d;
    logic [DATA_W-1:0] w_data_e;
    ex_ctrl_t          w_ctrl_d;
    ex_ctrl_t          w_ctrl_e;
    logic [CNT_W-1:0]  r_bubble_cnt;

    assign w_load   = !StallE;
    assign w_bubble = FlushE || (!StallE && !ValidD);

    assign w_data_d = {RD1D, RD2D, ImmExtD, PCD, PCPlus4D, Rs1D, Rs2D, RdD};

    always_comb begin
        w_ctrl_d             = '0;
        w_ctrl_d.reg_write   = RegWriteD;
        w_ctrl_d.mem_write   = MemWriteD;
        w_ctrl_d.jump        = JumpD;
        w_ctrl_d.branch      = BranchD;
        w_ctrl_d.alu_src     = ALUSrcD;
        w_ctrl_d.result_src  = result_src_e'(ResultSrcD);
        w_ctrl_d.alu_control = alu_ctrl_e'(ALUControlD);
        w_ctrl_d.valid       = ValidD;
    end

    pipe_reg #(.W(DATA_W)) u_data (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (FlushE),
        .i_en  (w_load),
        .i_d   (w_data_d),
        .o_q   (w_data_e)
    );

    pipe_reg #(.W(EX_CTRL_W)) u_ctrl (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (FlushE),
        .i_en  (w_load),
        .i_d   (w_ctrl_d),
        .o_q   (w_ctrl_e)
    );

    assign {RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE} = w_data_e;

    assign RegWriteE   = w_ctrl_e.reg_write;
    assign MemWriteE   = w_ctrl_e.mem_write;
    assign JumpE       = w_ctrl_e.jump;
    assign BranchE     = w_ctrl_e.branch;
    assign ALUSrcE     = w_ctrl_e.alu_src;
    assign ResultSrcE  = w_ctrl_e.result_src;
    assign ALUControlE = w_ctrl_e.alu_control;
    assign ValidE      = w_ctrl_e.valid;

    // Saturates at all-ones so a long-running core never reports a small count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
        end else if (w_bubble && (r_bubble_cnt != {CNT_W{1'b1}})) begin
            r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end
    end

    assign BubbleCntE = r_bubble_cnt;

endmodule

// File: doc/id_ex_register.md
# id_ex_register

Decode/Execute pipeline register for the 5-stage RISC-V core. It captures everything the decode stage produces and presents it to the execute stage one cycle later: register-file read data, the sign-extended immediate, PCs, register indices and control bits. It honours hazard-unit stall and flush requests. A saturating bubble counter supports debug and performance analysis.

## Interface
Parameters:
- XLEN, 32, datapath width
- CNT_W, 16, bubble counter width

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rst_n  in  1  synchronous, active-low reset
- StallE  in  1  hazard unit: hold current contents
- FlushE  in  1  hazard unit: insert bubble
- ValidD  in  1  decode slot holds a real instruction
- RD1D, RD2D  in  XLEN  register-file read data
- ImmExtD  in  XLEN  immediate from the sign-extend unit
- PCD, PCPlus4D  in  XLEN  instruction PC and PC+4
- Rs1D, Rs2D, RdD  in  5  register indices (forwarding/hazard use)
- RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD  in  1  control bits
- ResultSrcD  in  2  writeback mux select
- ALUControlD  in  3  ALU operation
- all of the above with suffix E  out  same widths  registered copies
- ValidE  out  1  execute slot holds a real instruction
- BubbleCntE  out  CNT_W  number of bubbles inserted since reset, saturating

## Operation
- Priority per edge: reset > flush > stall > load.
- Reset (rst_n=0 at edge):
  - every E output, including ValidE, is set to 0
  - BubbleCntE is set to 0
- Flush (FlushE=1):
  - all E fields, data and control, are set to 0, which forms a NOP bubble
  - ValidE is set to 0
  - FlushE overrides StallE
- Stall (StallE=1, FlushE=0):
  - all E fields hold their value
  - BubbleCntE holds
- Load (StallE=0, FlushE=0):
  - every D input is copied to its E counterpart
  - ValidE follows ValidD
- Bubble counting:
  - BubbleCntE increments by 1 on each edge where flush applies, or where a load occurs with ValidD=0
  - It saturates at 2^CNT_W−1 and never wraps.
- A zeroed bubble has RegWriteE=0 and MemWriteE=0, so it has no architectural side effect.
- Field widths pass through unchanged. No arithmetic is done on data fields.

## Timing
- Latency is 1 cycle from D inputs to E outputs on a load.
- Outputs are driven purely from registers. There is no combinational path from any input to any output.
- StallE and FlushE are sampled only at the rising edge. They must be stable before it.
- Reset during a stall or flush: reset wins and all outputs read 0 after that edge.
- Simultaneous FlushE=1 and StallE=1: the flush is applied. This matches a load-use stall combined with a taken-branch flush.
- Back-to-back flushes: each edge counts one bubble.
- With rst_n held low, outputs stay 0 for every cycle it is low.

## Structure
- Shared package riscv_pkg holds:
  - ResultSrc encodings (00 ALU, 01 memory, 10 PC+4)
  - ALUControl encoding and width
  - ImmSrc encodings (00 I, 01 S, 10 B, 11 U)
  - XLEN
- One sub-module, pipe_reg: a parameterised-width register with synchronous active-low reset, synchronous clear and enable.
  - It is instantiated once for the data group and once for the control/valid group.
  - The bubble counter lives in id_ex_register itself.

## Test plan
- Reset: drive all D inputs to 0xFFFFFFFF and ones, hold rst_n=0 for 3 edges -> every E output is 0 and BubbleCntE=0.
- Load: ImmExtD=0xFFFFF800, RD1D=0x12345678, RdD=5, RegWriteD=1, ValidD=1, no stall or flush -> values appear on E outputs exactly 1 edge later and BubbleCntE is unchanged.
- Stall: load the previous values, then StallE=1 for 4 edges while the D inputs change to 0xA5A5A5A5 -> E outputs keep the earlier values. After release, the new values appear 1 edge later.
- Flush priority: FlushE=1 and StallE=1 together with valid inputs -> all E outputs are 0, ValidE=0 and BubbleCntE increments by 1.
- Invalid load: ValidD=0 with StallE=0 and FlushE=0 for 3 edges -> ValidE=0 and BubbleCntE increases by 3.
- Saturation: with CNT_W=4, assert FlushE for 20 edges -> BubbleCntE stops at 15. A following reset returns it to 0.
